alu_multicycle: RTL

//  Parametrised successor to the single-cycle datapath ALU. Adds AND/OR/SLT
//  and iterative unsigned MULTU/DIVU writing internal HI/LO registers, read

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_muldiv_step.sv | 46 ++++
 rtl/alu_multicycle.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multicycle EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the unsigned multiplier (shift-add) or divider (restoring).
// hi/lo hold acc/multiplier for MUL and remainder/quotient for DIV.
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_t       mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    hi_next = '0;
    lo_next = '0;

    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

    // When the divisor fits, the true difference is below the divisor, so the
    // WIDTH-bit wrapped subtraction is exact.
    shifted = {hi, lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;

    if (mode == STEP_MUL) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (fits) begin
      hi_next = diff;
      lo_next = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = shifted[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU into
// HI/LO, read back with MFHI/MFLO. The pipeline stalls while busy is high.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             slt;
  step_mode_t       step_mode;

  assign slt       = ($signed(input1) < $signed(input2));
  assign step_mode = (state == S_DIV) ? STEP_DIV : STEP_MUL;

  always_comb begin
    alu_out = '0;
    case (control)
      ALU_AND:  alu_out = input1 & input2;
      ALU_OR:   alu_out = input1 | input2;
      ALU_ADD:  alu_out = input1 + input2;
      ALU_SUB:  alu_out = input1 - input2;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt};
      ALU_MFHI: alu_out = hi;
      ALU_MFLO: alu_out = lo;
      default:  alu_out = '0;
    endcase
  end

  alu_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (step_mode),
    .hi      (work_hi),
    .lo      (work_lo),
    .opnd    (opnd),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the whole datapath, HI/LO included, is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      opnd        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (control)
              ALU_MULTU: begin
                work_hi <= '0;
                work_lo <= input2;
                opnd    <= input1;
                cnt     <= CNT_W'(WIDTH);
                busy    <= 1'b1;
                state   <= S_MUL;
              end
              ALU_DIVU: begin
                if (input2 == '0) begin
                  hi          <= input1;
                  lo          <= '1;
                  result      <= '1;
                  zero        <= 1'b0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= S_FIN;
                end else begin
                  work_hi <= '0;
                  work_lo <= input1;
                  opnd    <= input2;
                  cnt     <= CNT_W'(WIDTH);
                  busy    <= 1'b1;
                  state   <= S_DIV;
                end
              end
              default: begin
                result <= alu_out;
                zero   <= (alu_out == '0);
                done   <= 1'b1;
                state  <= S_FIN;
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            hi     <= step_hi;
            lo     <= step_lo;
            result <= step_lo;
            zero   <= (step_lo == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
